// File: rtl/dual_port_mem_responder.sv
// dual_port_mem_responder: fixed-latency memory responder for a read-only fetch port and a read/write data port.
// Optional MEM_STAT_EN adds completed-operation counters num_reads1, num_reads2 and num_writes2.
module dual_port_mem_responder #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 readM1,
    input  logic [WORD_SIZE-1:0] address1,
    output logic [WORD_SIZE-1:0] data1,
    output logic                 ack1,
    input  logic                 readM2,
    input  logic                 writeM2,
    input  logic [WORD_SIZE-1:0] address2,
    inout  wire  [WORD_SIZE-1:0] data2,
    output logic                 ack2
`ifdef MEM_STAT_EN
    ,
    output logic [WORD_SIZE-1:0] num_reads1,
    output logic [WORD_SIZE-1:0] num_reads2,
    output logic [WORD_SIZE-1:0] num_writes2
`endif
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [3:0] LAT = 4'(LATENCY);
    logic [WORD_SIZE-1:0] mem_q [2**ADDR_BITS];
    state_t state1_q, state1_d, state2_q, state2_d;
    logic [3:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [ADDR_BITS-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic [WORD_SIZE-1:0] data1_q, data1_d, rdata2_q, rdata2_d, wdata2_q, wdata2_d;
    logic ack1_q, ack1_d, ack2_q, ack2_d, wr2_q, wr2_d;
    logic acc1, acc2, done1, done2;
    logic unused_addr;
    // Only the low ADDR_BITS index storage, so addresses wrap.
    assign unused_addr = ^{address1[WORD_SIZE-1:ADDR_BITS], address2[WORD_SIZE-1:ADDR_BITS]};
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state1_q <= IDLE;
            state2_q <= IDLE;
            cnt1_q   <= '0;
            cnt2_q   <= '0;
            addr1_q  <= '0;
            addr2_q  <= '0;
            data1_q  <= '0;
            rdata2_q <= '0;
            wdata2_q <= '0;
            ack1_q   <= 1'b0;
            ack2_q   <= 1'b0;
            wr2_q    <= 1'b0;
        end else begin
            state1_q <= state1_d;
            state2_q <= state2_d;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
            addr1_q  <= addr1_d;
            addr2_q  <= addr2_d;
            data1_q  <= data1_d;
            rdata2_q <= rdata2_d;
            wdata2_q <= wdata2_d;
            ack1_q   <= ack1_d;
            ack2_q   <= ack2_d;
            wr2_q    <= wr2_d;
        end
    end
    // A request completes on the edge where the down-counter leaves 1.
    always_comb begin
        acc1     = state1_q == IDLE && readM1;
        done1    = state1_q == BUSY && cnt1_q == 4'd1;
        state1_d = acc1 ? BUSY : done1 ? IDLE : state1_q;
        cnt1_d   = acc1 ? LAT : state1_q == BUSY ? cnt1_q - 4'd1 : cnt1_q;
        addr1_d  = acc1 ? address1[ADDR_BITS-1:0] : addr1_q;
        acc2     = state2_q == IDLE && (readM2 || writeM2);
        done2    = state2_q == BUSY && cnt2_q == 4'd1;
        state2_d = acc2 ? BUSY : done2 ? IDLE : state2_q;
        cnt2_d   = acc2 ? LAT : state2_q == BUSY ? cnt2_q - 4'd1 : cnt2_q;
        addr2_d  = acc2 ? address2[ADDR_BITS-1:0] : addr2_q;
        wr2_d    = acc2 ? writeM2 : wr2_q;
        wdata2_d = acc2 ? data2 : wdata2_q;
    end
    always_comb begin
        ack1_d   = done1;
        data1_d  = done1 ? mem_q[addr1_q] : data1_q;
        ack2_d   = done2;
        rdata2_d = done2 && !wr2_q ? mem_q[addr2_q] : rdata2_q;
    end
    // Storage survives reset; a same-edge port 1 read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (done2 && wr2_q) mem_q[addr2_q] <= wdata2_q;
    end
    assign data1 = data1_q;
    assign ack1  = ack1_q;
    assign ack2  = ack2_q;
    assign data2 = ack2_q && !wr2_q ? rdata2_q : {WORD_SIZE{1'bz}};
`ifdef MEM_STAT_EN
    logic [WORD_SIZE-1:0] num_reads1_q, num_reads2_q, num_writes2_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_reads1_q  <= '0;
            num_reads2_q  <= '0;
            num_writes2_q <= '0;
        end else begin
            num_reads1_q  <= num_reads1_q + WORD_SIZE'(done1);
            num_reads2_q  <= num_reads2_q + WORD_SIZE'(done2 && !wr2_q);
            num_writes2_q <= num_writes2_q + WORD_SIZE'(done2 && wr2_q);
        end
    end
    assign num_reads1  = num_reads1_q;
    assign num_reads2  = num_reads2_q;
    assign num_writes2 = num_writes2_q;
`endif
endmodule

// File: tb/tb_dual_port_mem_responder.sv
// tb_dual_port_mem_responder: directed and random stimulus against a cycle-scheduled reference model.
// Build with MEM_STAT_EN defined to also check the operation counters.
module tb_dual_port_mem_responder;
    localparam int W  = 16;
    localparam int AB = 8;
    localparam int L  = 2;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic readM1 = 1'b0, readM2 = 1'b0, writeM2 = 1'b0, d2_en = 1'b0;
    logic [W-1:0] address1 = '0, address2 = '0, d2_drv = '0;
    logic [W-1:0] data1;
    logic ack1, ack2;
    wire  [W-1:0] data2;
`ifdef MEM_STAT_EN
    logic [W-1:0] num_reads1, num_reads2, num_writes2;
`endif
    int checks = 0, errors = 0, cyc = 0;
    // Reference model: storage plus the edge at which each port's pending request completes.
    logic [W-1:0] ref_mem [1 << AB];
    bit p1_busy, p2_busy, p2_wr, rd2_now;
    int p1_at, p2_at, n_r1, n_r2, n_w2;
    logic [AB-1:0] p1_a, p2_a;
    logic [W-1:0] p2_wd, exp_d1, exp_d2;
    int ack_q[$];
    logic [W-1:0] dat_q[$];

    assign data2 = d2_en ? d2_drv : {W{1'bz}};
    always #5 clk = ~clk;

    dual_port_mem_responder #(.WORD_SIZE(W), .ADDR_BITS(AB), .LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n),
        .readM1(readM1), .address1(address1), .data1(data1), .ack1(ack1),
        .readM2(readM2), .writeM2(writeM2), .address2(address2), .data2(data2), .ack2(ack2)
`ifdef MEM_STAT_EN
        , .num_reads1(num_reads1), .num_reads2(num_reads2), .num_writes2(num_writes2)
`endif
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: bus is released around port 2 read responses, else parked at 0 or write data.
    task automatic step();
        bit ok, acc1, acc2, a1, a2;
        ok = !rd2_now && !(p2_busy && !p2_wr && p2_at == cyc + 1);
        writeM2 = writeM2 && ok;
        d2_en = ok;
        if (!writeM2) d2_drv = '0;
        @(posedge clk);
        #1;
        cyc++;
        acc1 = !p1_busy && readM1;
        acc2 = !p2_busy && (readM2 || writeM2);
        a1 = p1_busy && p1_at == cyc;
        a2 = p2_busy && p2_at == cyc;
        rd2_now = a2 && !p2_wr;
        if (a1) begin
            exp_d1 = ref_mem[p1_a];
            n_r1++;
            p1_busy = 1'b0;
        end
        if (rd2_now) begin
            exp_d2 = ref_mem[p2_a];
            n_r2++;
        end
        if (a2 && p2_wr) begin
            ref_mem[p2_a] = p2_wd;
            n_w2++;
        end
        if (a2) p2_busy = 1'b0;
        if (acc1) begin
            p1_busy = 1'b1;
            p1_at = cyc + L;
            p1_a = address1[AB-1:0];
        end
        if (acc2) begin
            p2_busy = 1'b1;
            p2_at = cyc + L;
            p2_a = address2[AB-1:0];
            p2_wr = writeM2;
            p2_wd = d2_drv;
        end
        check("ack1", W'(ack1), W'(a1));
        check("data1", data1, exp_d1);
        check("ack2", W'(ack2), W'(a2));
        if (rd2_now) check("data2_read", data2, exp_d2);
        else if (d2_en) check("data2_released", data2, d2_drv);
`ifdef MEM_STAT_EN
        check("num_reads1", num_reads1, W'(n_r1));
        check("num_reads2", num_reads2, W'(n_r2));
        check("num_writes2", num_writes2, W'(n_w2));
`endif
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        readM1 = 1'b0;
        readM2 = 1'b0;
        writeM2 = 1'b0;
        d2_en = 1'b1;
        d2_drv = '0;
        #1;
        if (cyc > 0) begin
            check("rst_async_ack1", W'(ack1), '0);
            check("rst_async_ack2", W'(ack2), '0);
            check("rst_async_data1", data1, '0);
        end
        @(posedge clk);
        #1;
        cyc++;
        check("rst_ack1", W'(ack1), '0);
        check("rst_ack2", W'(ack2), '0);
        check("rst_data1", data1, '0);
        check("rst_data2", data2, '0);
`ifdef MEM_STAT_EN
        check("rst_num_reads1", num_reads1, '0);
        check("rst_num_reads2", num_reads2, '0);
        check("rst_num_writes2", num_writes2, '0);
`endif
        reset_n = 1'b1;
        p1_busy = 1'b0;
        p2_busy = 1'b0;
        rd2_now = 1'b0;
        exp_d1 = '0;
        n_r1 = 0;
        n_r2 = 0;
        n_w2 = 0;
    endtask

    task automatic p2_write(input logic [W-1:0] a, input logic [W-1:0] d);
        writeM2 = 1'b1;
        address2 = a;
        d2_drv = d;
        step();
        writeM2 = 1'b0;
        repeat (L) step();
        check("p2_write_ack", W'(ack2), 16'd1);
    endtask

    task automatic p2_read(input logic [W-1:0] a, input logic [W-1:0] exp);
        readM2 = 1'b1;
        address2 = a;
        step();
        check("p2_read_before", data2, '0);
        readM2 = 1'b0;
        repeat (L) step();
        check("p2_read_ack", W'(ack2), 16'd1);
        check("p2_read_data", data2, exp);
        step();
        d2_en = 1'b1;
        d2_drv = '0;
        #1;
        check("p2_read_after", data2, '0);
    endtask

    task automatic p1_read(input logic [W-1:0] a, input logic [W-1:0] exp);
        readM1 = 1'b1;
        address1 = a;
        step();
        readM1 = 1'b0;
        repeat (L) step();
        check("p1_read_ack", W'(ack1), 16'd1);
        check("p1_read_data", data1, exp);
        step();
        check("p1_read_ack_off", W'(ack1), '0);
        check("p1_read_held", data1, exp);
    endtask

    initial begin
        pulse_reset();
        for (int a = 0; a < (1 << AB); a++) p2_write(W'(a), W'($urandom) | 16'h0001);
        p2_write(16'h0005, 16'hBEEF);
        p2_read(16'h0005, 16'hBEEF);
        p2_write(16'h0010, 16'h1234);
        p1_read(16'h0010, 16'h1234);
        p2_write(16'h0103, 16'hAAAA);
        p1_read(16'h0003, 16'hAAAA);
        readM1 = 1'b1;
        address1 = 16'h0003;
        writeM2 = 1'b1;
        address2 = 16'h0003;
        d2_drv = 16'h5555;
        step();
        readM1 = 1'b0;
        writeM2 = 1'b0;
        repeat (L) step();
        check("collision_old", data1, 16'hAAAA);
        p1_read(16'h0003, 16'h5555);
        // Address changes while BUSY must not affect the first response.
        readM1 = 1'b1;
        address1 = 16'h0010;
        step();
        for (int i = 0; i < 5; i++) begin
            address1 = 16'h0005;
            step();
            if (ack1) begin
                ack_q.push_back(cyc);
                dat_q.push_back(data1);
            end
        end
        readM1 = 1'b0;
        check("b2b_ack_count", W'(ack_q.size()), 16'd2);
        if (ack_q.size() == 2) begin
            check("b2b_first_data", dat_q[0], 16'h1234);
            check("b2b_period", W'(ack_q[1] - ack_q[0]), W'(L + 1));
            check("b2b_second_data", dat_q[1], 16'hBEEF);
        end
        step();
        readM2 = 1'b1;
        writeM2 = 1'b1;
        address2 = 16'h0030;
        d2_drv = 16'h0F0F;
        step();
        readM2 = 1'b0;
        writeM2 = 1'b0;
        repeat (L) step();
        check("both_ack2", W'(ack2), 16'd1);
        check("both_no_drive", data2, '0);
        p2_read(16'h0030, 16'h0F0F);
        p2_write(16'h0020, 16'h3C3C);
        writeM2 = 1'b1;
        address2 = 16'h0020;
        d2_drv = 16'h7777;
        step();
        writeM2 = 1'b0;
        step();
        pulse_reset();
        repeat (L) step();
        check("rst_no_ack2", W'(ack2), '0);
        p2_read(16'h0020, 16'h3C3C);
`ifdef MEM_STAT_EN
        pulse_reset();
        repeat (3) p1_read(16'h0010, 16'h1234);
        p2_write(16'h0040, 16'h4242);
        p2_write(16'h0041, 16'h4343);
        p2_read(16'h0040, 16'h4242);
        check("stat_reads1", num_reads1, 16'd3);
        check("stat_reads2", num_reads2, 16'd1);
        check("stat_writes2", num_writes2, 16'd2);
        pulse_reset();
`endif
        for (int i = 0; i < 600; i++) begin
            readM1 = $urandom_range(0, 1) == 1;
            address1 = W'($urandom) & 16'h013F;
            readM2 = $urandom_range(0, 3) == 0;
            writeM2 = $urandom_range(0, 2) == 0;
            address2 = W'($urandom) & 16'h013F;
            d2_drv = W'($urandom);
            step();
        end
        readM1 = 1'b0;
        readM2 = 1'b0;
        writeM2 = 1'b0;
        repeat (L + 2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
